// File: rtl/btb_pkg.sv
// Shared types and constants for the set-associative branch target buffer.
// Entry field widths are fixed here; btb_assoc's ADDR/TAG/CNT parameters
// must match BTB_ADDR/BTB_TAG/BTB_CNT.
`ifndef BtbCntWidth
`define BtbCntWidth 2
`endif

package btb_pkg;
  localparam int BTB_ADDR = 32;
  localparam int BTB_TAG  = 16;
  localparam int BTB_CNT  = `BtbCntWidth;

  // Saturated (strongly taken) and freshly allocated (weakly taken) counts.
  localparam logic [BTB_CNT-1:0] BTB_CNT_MAX  = {BTB_CNT{1'b1}};
  localparam logic [BTB_CNT-1:0] BTB_CNT_WEAK = BTB_CNT'(1) << (BTB_CNT - 1);

  typedef struct packed {
    logic                valid;
    logic                is_jump;
    logic [BTB_TAG-1:0]  tag;
    logic [BTB_ADDR-1:0] target;
    logic [BTB_CNT-1:0]  cnt;
  } btb_entry_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } btb_state_t;
endpackage

// File: rtl/btb_assoc_lookup.sv
// Tag compare across the WAYS entries of one set.
// Ports:
//   ents      in  WAYS entries of the selected set
//   addr      in  address being looked up (tag taken from addr[2+IDX +: TAG])
//   match     out some way is valid with a matching tag
//   match_way out lowest matching way
//   hit       out some matching way predicts taken (jump, or counter MSB set)
//   target    out target of the lowest predicting way, 0 when no hit
module btb_assoc_lookup
  import btb_pkg::*;
#(
  parameter int WAYS = 2,
  parameter int ADDR = BTB_ADDR,
  parameter int TAG  = BTB_TAG,
  parameter int IDX  = 4,
  parameter int WAYW = 1
) (
  input  btb_entry_t [WAYS-1:0] ents,
  input  logic [ADDR-1:0]       addr,
  output logic                  match,
  output logic [WAYW-1:0]       match_way,
  output logic                  hit,
  output logic [ADDR-1:0]       target
);
  logic [TAG-1:0] tag;
  logic           addr_unused;

  assign tag         = addr[2+IDX +: TAG];
  assign addr_unused = ^addr;

  // Scan from the top way down so the lowest way overwrites last and wins.
  always_comb begin
    match     = 1'b0;
    match_way = '0;
    hit       = 1'b0;
    target    = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (ents[w].valid && ents[w].tag == tag) begin
        match     = 1'b1;
        match_way = WAYW'(w);
        if (ents[w].is_jump || ents[w].cnt[BTB_CNT-1]) begin
          hit    = 1'b1;
          target = ents[w].target;
        end
      end
    end
  end
endmodule

// File: rtl/btb_assoc.sv
// Set-associative, multi-lane branch target buffer.
// Lookup is combinational from pc (lane i predicts pc+4*i); training is
// registered from the commit port. A clear sequence walks every set after
// reset or flush, invalidating entries and resetting replacement pointers.
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   flush              pulse: invalidate all entries
//   busy               clear sequence in progress
//   pc                 lane-0 fetch address
//   btb_hit/btb_addr   per-lane taken prediction and target (lane i at [i*ADDR +: ADDR])
//   br_commit/br_taken/br_miss   committing conditional branch
//   jump_commit/jump_miss        committing jump
//   com_addr/com_tar_addr        committing address and resolved target
module btb_assoc
  import btb_pkg::*;
#(
  parameter int ADDR  = BTB_ADDR,
  parameter int SETS  = 16,
  parameter int WAYS  = 2,
  parameter int FETCH = 2,
  parameter int TAG   = BTB_TAG,
  parameter int CNT   = BTB_CNT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  output logic                  busy,
  input  logic [ADDR-1:0]       pc,
  output logic [FETCH-1:0]      btb_hit,
  output logic [FETCH*ADDR-1:0] btb_addr,
  input  logic                  br_commit,
  input  logic                  br_taken,
  input  logic                  br_miss,
  input  logic                  jump_commit,
  input  logic                  jump_miss,
  input  logic [ADDR-1:0]       com_addr,
  input  logic [ADDR-1:0]       com_tar_addr
);
  localparam int IDX  = $clog2(SETS);
  localparam int WAYW = (WAYS > 1) ? $clog2(WAYS) : 1;

  btb_entry_t [WAYS-1:0] tbl [SETS];
  logic [WAYW-1:0]       rr  [SETS];
  btb_state_t            state;
  logic [IDX-1:0]        clr_idx;

  assign busy = reset || (state == CLEAR);

  // ---------------- lookup lanes ----------------
  for (genvar i = 0; i < FETCH; i++) begin : g_lane
    logic [ADDR-1:0]       la;
    btb_entry_t [WAYS-1:0] set_ents;
    logic                  lh, lm;
    logic [WAYW-1:0]       lw;
    logic [ADDR-1:0]       lt;
    logic                  lane_unused;

    assign la          = pc + ADDR'(4 * i);
    assign set_ents    = tbl[la[2 +: IDX]];
    assign lane_unused = ^{lm, lw};

    btb_assoc_lookup #(
      .WAYS(WAYS), .ADDR(ADDR), .TAG(TAG), .IDX(IDX), .WAYW(WAYW)
    ) u_lookup (
      .ents(set_ents), .addr(la), .match(lm), .match_way(lw),
      .hit(lh), .target(lt)
    );

    assign btb_hit[i]              = lh && !busy;
    assign btb_addr[i*ADDR +: ADDR] = (lh && !busy) ? lt : '0;
  end

  // ---------------- commit side ----------------
  logic [IDX-1:0]        com_set;
  btb_entry_t [WAYS-1:0] com_ents;
  logic                  c_match, c_hit;
  logic [WAYW-1:0]       c_way;
  logic [ADDR-1:0]       c_tgt;
  logic                  com_unused;

  assign com_set    = com_addr[2 +: IDX];
  assign com_ents   = tbl[com_set];
  assign com_unused = ^{c_hit, c_tgt, jump_miss};

  btb_assoc_lookup #(
    .WAYS(WAYS), .ADDR(ADDR), .TAG(TAG), .IDX(IDX), .WAYW(WAYW)
  ) u_com_lookup (
    .ents(com_ents), .addr(com_addr), .match(c_match), .match_way(c_way),
    .hit(c_hit), .target(c_tgt)
  );

  // Victim: lowest invalid way, else the set's round-robin pointer.
  logic            has_inv;
  logic [WAYW-1:0] inv_way, victim, rr_next;

  always_comb begin
    has_inv = 1'b0;
    inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!com_ents[w].valid) begin
        has_inv = 1'b1;
        inv_way = WAYW'(w);
      end
    end
    victim  = has_inv ? inv_way : rr[com_set];
    rr_next = (rr[com_set] == WAYW'(WAYS - 1)) ? '0 : rr[com_set] + WAYW'(1);
  end

  btb_entry_t new_ent;
  always_comb begin
    new_ent         = '0;
    new_ent.valid   = 1'b1;
    new_ent.is_jump = jump_commit;
    new_ent.tag     = com_addr[2+IDX +: TAG];
    new_ent.target  = com_tar_addr;
    new_ent.cnt     = jump_commit ? BTB_CNT_MAX : BTB_CNT_WEAK;
  end

  logic [CNT-1:0] cur_cnt, cnt_inc, cnt_dec;
  assign cur_cnt = com_ents[c_way].cnt;
  assign cnt_inc = (cur_cnt == BTB_CNT_MAX) ? cur_cnt : cur_cnt + CNT'(1);
  assign cnt_dec = (cur_cnt == '0) ? cur_cnt : cur_cnt - CNT'(1);

  // A miss allocates on a jump or a taken branch; a not-taken miss is ignored.
  logic do_alloc;
  assign do_alloc = !c_match && (jump_commit || (br_commit && br_taken));

  // ---------------- state / table update ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= CLEAR;
      clr_idx <= '0;
    end else if (state == CLEAR) begin
      for (int w = 0; w < WAYS; w++) tbl[clr_idx][w].valid <= 1'b0;
      rr[clr_idx] <= '0;
      clr_idx     <= clr_idx + IDX'(1);
      if (clr_idx == IDX'(SETS - 1)) state <= IDLE;
    end else if (flush) begin
      state   <= CLEAR;
      clr_idx <= '0;
    end else if (jump_commit || br_commit) begin
      if (do_alloc) begin
        tbl[com_set][victim] <= new_ent;
        if (!has_inv) rr[com_set] <= rr_next;
      end else if (c_match && jump_commit) begin
        tbl[com_set][c_way].target  <= com_tar_addr;
        tbl[com_set][c_way].cnt     <= BTB_CNT_MAX;
        tbl[com_set][c_way].is_jump <= 1'b1;
      end else if (c_match && br_taken) begin
        tbl[com_set][c_way].cnt <= cnt_inc;
        if (br_miss) tbl[com_set][c_way].target <= com_tar_addr;
      end else if (c_match) begin
        tbl[com_set][c_way].cnt <= cnt_dec;
      end
    end
  end

  // Both commit kinds in one cycle is a pipeline bug; the jump is applied.
  always @(posedge clk) begin
    if (!reset && state == IDLE && !flush)
      assert (!(br_commit && jump_commit))
      else $warning("btb_assoc: br_commit and jump_commit together, jump applied");
  end
endmodule

// File: doc/btb_assoc.md
Name: btb_assoc

Overview:
- Set-associative, multi-lane branch target buffer for the fetch stage. Next-generation BTB: WAYS-way sets, FETCH parallel lookup lanes, per-entry jump/branch type, saturating hysteresis counters, round-robin replacement.
- A sequenced clear FSM handles reset and pipeline flush.
- Lookup is combinational from pc. Training is registered from commit.

Parameters:
- ADDR, 32: address width.
- SETS, 16: number of sets (power of 2, >=2); IDX = log2(SETS).
- WAYS, 2: associativity (>=1).
- FETCH, 2: lookup lanes; lane i predicts pc + 4*i.
- TAG, 16: partial tag width; tag = addr[2+IDX +: TAG].
- CNT, 2: hysteresis counter width (`BtbCntWidth).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  pulse: invalidate all entries.
- busy  out  1  clear sequence in progress.
- pc  in  ADDR  fetch address of lane 0.
- btb_hit  out  FETCH  per-lane predict-taken hit.
- btb_addr  out  FETCH*ADDR  per-lane target; lane i occupies bits [i*ADDR +: ADDR].
- br_commit  in  1  conditional branch committing.
- br_taken  in  1  committed branch was taken.
- br_miss  in  1  committed branch was mispredicted.
- jump_commit  in  1  jump committing.
- jump_miss  in  1  committed jump target was mispredicted.
- com_addr  in  ADDR  committing instruction address.
- com_tar_addr  in  ADDR  resolved target.

Behaviour:
- Entry fields: valid, is_jump, tag[TAG], target[ADDR], cnt[CNT]. Per-set round-robin pointer rr[log2 WAYS].
- Indexing: idx = addr[2 +: IDX]. Lane i uses pc+4*i; sets wrap modulo SETS.
- Lookup (0-cycle, combinational):
  - A lane hits if some way has valid && tag match && (is_jump || cnt MSB==1).
  - A hit returns that way's target.
  - A miss drives btb_hit=0 and btb_addr lane=0.
  - Multiple matching ways (illegal): the lowest way wins.
  - A lookup in the same cycle as an update to the same entry returns the old value (no bypass).
- Training (registered, on the clk edge; state IDLE only):
  - jump_commit, hit: target<=com_tar_addr, cnt<=max, is_jump<=1.
  - br_commit, hit, taken: cnt saturating +1; target<=com_tar_addr when br_miss.
  - br_commit, hit, not taken: cnt saturating -1. The entry stays valid at 0.
  - Miss with jump, or with taken branch: allocate. Victim is the lowest invalid way; if none, rr[set], and rr advances (mod WAYS).
    - New jump: cnt=max, is_jump=1.
    - New branch: cnt=2^(CNT-1) (weakly taken), is_jump=0.
  - Miss with not-taken branch: no change.
  - br_commit && jump_commit together: jump takes priority. Simulation assertion fires.
  - jump_miss is informational. Jump training is identical regardless of jump_miss.
- Clear FSM, states IDLE and CLEAR, counter clr_idx[IDX]:
  - reset=1 (any state, including mid-CLEAR): next state CLEAR, clr_idx<=0.
  - IDLE && flush: next state CLEAR, clr_idx<=0.
  - CLEAR, each cycle: valid<=0 for all ways of set clr_idx; rr[clr_idx]<=0; clr_idx++. When clr_idx==SETS-1, next state IDLE.
  - flush during CLEAR: ignored.
  - In CLEAR: busy=1, btb_hit=0, btb_addr=0, commits dropped.
  - After reset deasserts, busy stays high exactly SETS cycles.
- Reset values:
  - busy=1 while reset is high and through the clear sequence.
  - btb_hit=0, btb_addr=0.
  - Tag, target and cnt are not reset; only valid and rr are cleared.

Decomposition:
- Shared package btb_pkg:
  - btb_entry_t struct (valid, is_jump, tag, target, cnt).
  - btb_state_t enum {IDLE, CLEAR}.
  - CNT default tied to `BtbCntWidth.
  - Constants BTB_CNT_MAX and BTB_CNT_WEAK.
- Sub-module btb_assoc_lookup: one set's WAYS entries plus a lane address in, hit/target/way out. Instantiated FETCH times for lookup, and once for the commit port to find the hit way.

Test Plan:
(SETS=16, WAYS=2, FETCH=2, TAG=16, CNT=2 throughout.)
- Reset:
  - Stimulus: hold reset 3 cycles, then release.
  - Required: busy=1 for exactly 16 further cycles, then 0. btb_hit=2'b00 throughout.
- Jump:
  - Stimulus: jump_commit, com_addr=0xdeadbe74, com_tar_addr=0xcafecafc.
  - Required: next cycle pc=0xdeadbe74 gives btb_hit=2'b01, lane0 addr=0xcafecafc. pc=0xdeadbe70 gives btb_hit=2'b10, lane1 addr=0xcafecafc.
- Hysteresis (branch at 0x1000, target 0x2000):
  - Taken, miss: allocated cnt=2; hit.
  - Not-taken: cnt=1; pc=0x1000 misses.
  - Taken twice: cnt=3.
  - Taken again: saturates at 3.
  - Not-taken branch at 0x3000: no allocation; still misses.
- Replacement:
  - Stimulus: jumps at 0x100, 0x500, 0x900 (all index 0).
  - Required: 0x500 and 0x900 hit; 0x100 misses (way0 evicted); rr[0]=1.
- Flush:
  - Stimulus: after training, pulse flush.
  - Required: busy=1 for 16 cycles. A jump_commit at cycle 5 of busy is dropped. Afterwards all earlier addresses miss.
  - Stimulus: assert reset at cycle 8 of the clear.
  - Required: busy held for 16 cycles after reset deasserts.
- Simultaneous events:
  - Stimulus: br_commit (not-taken) and jump_commit to 0x40 in the same cycle.
  - Required: jump allocated; assertion reported.
  - Stimulus: commit updating 0x40 while pc=0x40.
  - Required: old value seen this cycle, new value the next cycle.
